dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single 256-bit data memory between two cache miss ports: port 0 is the data cache and port 1 is the instruction cache or a second core's dcache. It grants one requester at a time with round-robin fairness and holds the grant until the memory acknowledges. It forwards the acknowledge only to the granted port. It sits between the cache controllers' memory interfaces and the data memory.

## Interface
- TIMEOUT_CYCLES, default 1023: cycles a grant may stay open without ack before forced release (only with the watchdog compiled in).
- CNT_W, default 10: watchdog counter width; TIMEOUT_CYCLES must be less than 2**CNT_W.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- pN_enable_i  in  1  request from port N (N = 0, 1); held high until pN_ack_o is seen.
- pN_write_i  in  1  1 = write-back, 0 = line fill.
- pN_addr_i  in  32  line address; bits [4:0] are zero.
- pN_data_i  in  256  write line.
- pN_data_o  out  256  read line; mem_data_i broadcast to both ports, valid only with pN_ack_o.
- pN_ack_o  out  1  mem_ack_i gated by the grant to port N.
- mem_enable_o  out  1  request to memory.
- mem_write_o  out  1  write strobe.
- mem_addr_o  out  32  address.
- mem_data_o  out  256  write line.
- mem_data_i  in  256  read line.
- mem_ack_i  in  1  single-cycle completion pulse.
- grant_o  out  2  one-hot current owner; 00 = idle.
- err_o  out  1  sticky watchdog error.

## Operation
- States:
  - IDLE: no owner.
  - GNT0: port 0 owns memory.
  - GNT1: port 1 owns memory.
- IDLE with only pN_enable_i high: go to GNTN.
- IDLE with both enables high: grant the port opposite last_grant, then update last_grant.
- GNTN: mem_* outputs are a combinational mux of port N's enable/write/addr/data. The other port sees ack 0.
- GNTN with mem_ack_i = 1: pN_ack_o = 1 that cycle. Next state IDLE unconditionally, giving a one-cycle bubble. A cache that chains write-back into a fill (enable held high) therefore re-arbitrates and may lose to the other port.
- GNTN with pN_enable_i = 0 and no ack (requester abort): return to IDLE and drop mem_enable_o in the same cycle.
- In IDLE, mem_enable_o = 0 and mem_write_o = 0. mem_addr_o and mem_data_o take port 0's values (don't-care).
- Reset values: state IDLE, last_grant = 1 (port 0 wins the first tie), grant_o = 00, all acks 0, mem_enable_o 0, mem_write_o 0, err_o 0, counter 0.
- Reset asserted mid-transfer: grant dropped immediately (asynchronous). The memory sees enable fall and any in-flight ack is ignored.

## Timing
- Request first seen high in IDLE at cycle T: grant_o and mem_enable_o are high from cycle T+1.
- Ack at cycle M: pN_ack_o is high in M (combinational). IDLE in M+1. The earliest next grant is visible in M+2.
- A port whose enable is still high in M+1 is treated as a new request.
- Ack arriving while IDLE is discarded and reaches no port.

## Configuration
- DMEM_ARB_WATCHDOG_EN defined:
  - CNT_W-bit counter clears on entry to GNTN and increments each granted cycle without ack.
  - When it reaches TIMEOUT_CYCLES: set err_o (sticky until reset), force next state IDLE, and flip last_grant so the other port is served next.
- DMEM_ARB_WATCHDOG_EN undefined: no counter, err_o tied 0, grants are held indefinitely.

## Structure
- Package dmem_arb_pkg:
  - state encoding localparams IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2;
  - port-index constants;
  - line width 256 and address width 32.
- Sub-module dmem_arb_watchdog (counter, compare, sticky err). Instantiated only under the macro.
- State register, last_grant register and output muxes stay in the top module.

## Test plan
- Port 0 alone requests a read at T; memory acks at T+10 -> grant_o = 01 at T+1, p0_ack_o = 1 at T+10 only, p1_ack_o = 0 throughout, grant_o = 00 at T+11.
- Both ports request in the same cycle after reset -> port 0 granted first. Port 1 is granted at ack+2 with its address 0x0000_0400 on mem_addr_o.
- Port 0 issues write-back then a fill with enable held high while port 1 is waiting -> order is p0 write, p1, p0 read; mem_write_o = 1 only during the first grant.
- Port 1 granted, then p1_enable_i drops with no ack -> mem_enable_o = 0 in that same cycle, IDLE next cycle, err_o stays 0.
- With DMEM_ARB_WATCHDOG_EN and TIMEOUT_CYCLES = 8: memory never acks -> err_o = 1 at grant+8, grant released, and err_o stays 1 until rst_i pulses low.
- rst_i pulsed low during an active port-0 grant -> grant_o = 00 and mem_enable_o = 0 asynchronously. A later mem_ack_i produces no pN_ack_o.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants and state encoding for the two-port data-memory arbiter.
package dmem_arb_pkg;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_GNT0 = GNT0,
      ST_GNT1 = GNT1
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two cache miss ports, the arbiter and the data memory.
// Signal suffixes are from the arbiter's point of view (slave modport).
interface dmem_arbiter_if;
   import dmem_arb_pkg::*;

   logic              p0_enable_i;
   logic              p0_write_i;
   logic [ADDR_W-1:0] p0_addr_i;
   logic [LINE_W-1:0] p0_data_i;
   logic [LINE_W-1:0] p0_data_o;
   logic              p0_ack_o;

   logic              p1_enable_i;
   logic              p1_write_i;
   logic [ADDR_W-1:0] p1_addr_i;
   logic [LINE_W-1:0] p1_data_i;
   logic [LINE_W-1:0] p1_data_o;
   logic              p1_ack_o;

   logic              mem_enable_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;

   modport slave (
      input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
      output p0_data_o, p0_ack_o,
      input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
      output p1_data_o, p1_ack_o,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i
   );

   modport master (
      output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
      input  p0_data_o, p0_ack_o,
      output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
      input  p1_data_o, p1_ack_o,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i
   );

endinterface

// File: rtl/dmem_arb_watchdog.sv
// Grant watchdog: counts granted cycles without ack, raises a one-cycle timeout
// when the count reaches TIMEOUT_CYCLES and latches a sticky error.
module dmem_arb_watchdog
   import dmem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int CNT_W          = 10
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic granted_i,
   input  logic ack_i,
   output logic timeout_o,
   output logic err_o
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             err_q, err_d;

   assign cnt_inc = cnt_q + 1'b1;

   // Counter sits at zero whenever nothing is granted, so each new grant starts clean.
   always_comb begin
      cnt_d     = '0;
      err_d     = err_q;
      timeout_o = 1'b0;
      if (granted_i && !ack_i) begin
         if (cnt_inc == LIMIT) begin
            timeout_o = 1'b1;
            err_d     = 1'b1;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the 256-bit data memory between two cache miss ports.
// Optional grant watchdog compiled in with DMEM_ARB_WATCHDOG_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int CNT_W          = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   dmem_arbiter_if.slave        bus,
   output logic [1:0]           grant_o,
   output logic                 err_o
);

   arb_state_e state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       timeout;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         last_grant_q <= PORT1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // last_grant follows every grant so a chained request re-arbitrates behind a waiting port.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.p0_enable_i && bus.p1_enable_i) begin
               if (last_grant_q == PORT1) begin
                  state_d      = ST_GNT0;
                  last_grant_d = PORT0;
               end else begin
                  state_d      = ST_GNT1;
                  last_grant_d = PORT1;
               end
            end else if (bus.p0_enable_i) begin
               state_d      = ST_GNT0;
               last_grant_d = PORT0;
            end else if (bus.p1_enable_i) begin
               state_d      = ST_GNT1;
               last_grant_d = PORT1;
            end
         end
         ST_GNT0: begin
            if (bus.mem_ack_i || !bus.p0_enable_i) begin
               state_d = ST_IDLE;
            end else if (timeout) begin
               state_d      = ST_IDLE;
               last_grant_d = PORT0;
            end
         end
         ST_GNT1: begin
            if (bus.mem_ack_i || !bus.p1_enable_i) begin
               state_d = ST_IDLE;
            end else if (timeout) begin
               state_d      = ST_IDLE;
               last_grant_d = PORT1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Memory side follows the owner combinationally so an abort drops enable in the same cycle.
   always_comb begin
      bus.mem_enable_o = 1'b0;
      bus.mem_write_o  = 1'b0;
      bus.mem_addr_o   = bus.p0_addr_i;
      bus.mem_data_o   = bus.p0_data_i;
      bus.p0_ack_o     = 1'b0;
      bus.p1_ack_o     = 1'b0;
      case (state_q)
         ST_GNT0: begin
            bus.mem_enable_o = bus.p0_enable_i;
            bus.mem_write_o  = bus.p0_enable_i & bus.p0_write_i;
            bus.p0_ack_o     = bus.mem_ack_i;
         end
         ST_GNT1: begin
            bus.mem_enable_o = bus.p1_enable_i;
            bus.mem_write_o  = bus.p1_enable_i & bus.p1_write_i;
            bus.mem_addr_o   = bus.p1_addr_i;
            bus.mem_data_o   = bus.p1_data_i;
            bus.p1_ack_o     = bus.mem_ack_i;
         end
         default: ;
      endcase
   end

   assign bus.p0_data_o = bus.mem_data_i;
   assign bus.p1_data_o = bus.mem_data_i;
   assign grant_o       = {state_q == ST_GNT1, state_q == ST_GNT0};

`ifdef DMEM_ARB_WATCHDOG_EN
   dmem_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .granted_i (state_q != ST_IDLE),
      .ack_i     (bus.mem_ack_i),
      .timeout_o (timeout),
      .err_o     (err_o)
   );
`else
   logic unused_cfg;
   assign unused_cfg = ^{TIMEOUT_CYCLES[0], CNT_W[0]};
   assign timeout    = 1'b0;
   assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected grants are queued when requests are
// driven and popped when the arbiter raises a grant.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   typedef struct packed {
      logic [1:0]        grant;
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [1:0] grant_o;
   logic       err_o;

   dmem_arbiter_if bus ();

   dmem_arbiter #(
      .TIMEOUT_CYCLES (8),
      .CNT_W          (10)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .bus     (bus),
      .grant_o (grant_o),
      .err_o   (err_o)
   );

   always #5 clk_i = ~clk_i;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   task automatic push(input logic [1:0] g, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d);
      exp_t e;
      e.grant = g;
      e.write = w;
      e.addr  = a;
      e.data  = d;
      sb.push_back(e);
   endtask

   task automatic check_grant(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, LINE_W'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_grant"}, grant_o, e.grant);
         chk({tag, "_mem_en"}, bus.mem_enable_o, 1);
         chk({tag, "_mem_wr"}, bus.mem_write_o, e.write);
         chk({tag, "_mem_addr"}, bus.mem_addr_o, e.addr);
         chk({tag, "_mem_data"}, bus.mem_data_o, e.data);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed hang expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst_i           = 1'b0;
      bus.p0_enable_i = 1'b0;
      bus.p0_write_i  = 1'b0;
      bus.p0_addr_i   = '0;
      bus.p0_data_i   = '0;
      bus.p1_enable_i = 1'b0;
      bus.p1_write_i  = 1'b0;
      bus.p1_addr_i   = '0;
      bus.p1_data_i   = '0;
      bus.mem_data_i  = '0;
      bus.mem_ack_i   = 1'b0;

      // Reset state
      tick();
      smp();
      chk("rst_grant", grant_o, 0);
      chk("rst_mem_en", bus.mem_enable_o, 0);
      chk("rst_mem_wr", bus.mem_write_o, 0);
      chk("rst_p0_ack", bus.p0_ack_o, 0);
      chk("rst_p1_ack", bus.p1_ack_o, 0);
      chk("rst_err", err_o, 0);
      tick();
      rst_i = 1'b1;

      // Port 0 read alone, ack ten cycles after the request
      tick();
      bus.p0_enable_i = 1'b1;
      bus.p0_write_i  = 1'b0;
      bus.p0_addr_i   = 32'h1000_0020;
      bus.p0_data_i   = {8{32'hA5A5_0001}};
      push(2'b01, 1'b0, 32'h1000_0020, {8{32'hA5A5_0001}});
      smp();
      chk("t1_grant_T", grant_o, 0);
      tick();
      smp();
      check_grant("t1");
      for (int i = 2; i < 10; i++) begin
         tick();
         smp();
         chk("t1_p0_ack_wait", bus.p0_ack_o, 0);
         chk("t1_p1_ack_wait", bus.p1_ack_o, 0);
      end
      tick();
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = {8{32'hDEAD_BEEF}};
      smp();
      chk("t1_p0_ack", bus.p0_ack_o, 1);
      chk("t1_p1_ack", bus.p1_ack_o, 0);
      chk("t1_p0_data", bus.p0_data_o, {8{32'hDEAD_BEEF}});
      tick();
      bus.mem_ack_i   = 1'b0;
      bus.p0_enable_i = 1'b0;
      smp();
      chk("t1_grant_after", grant_o, 0);
      chk("t1_p0_ack_after", bus.p0_ack_o, 0);

      // Stray ack while idle reaches no port
      tick();
      bus.mem_ack_i = 1'b1;
      smp();
      chk("idle_ack_p0", bus.p0_ack_o, 0);
      chk("idle_ack_p1", bus.p1_ack_o, 0);
      tick();
      bus.mem_ack_i = 1'b0;
      smp();
      chk("idle_ack_grant", grant_o, 0);

      // Tie straight after reset: port 0 first, port 1 at ack+2
      do_reset();
      tick();
      bus.p0_enable_i = 1'b1;
      bus.p0_addr_i   = 32'h0000_0200;
      bus.p0_data_i   = {8{32'h0000_0002}};
      bus.p1_enable_i = 1'b1;
      bus.p1_write_i  = 1'b0;
      bus.p1_addr_i   = 32'h0000_0400;
      bus.p1_data_i   = {8{32'h1111_0400}};
      push(2'b01, 1'b0, 32'h0000_0200, {8{32'h0000_0002}});
      push(2'b10, 1'b0, 32'h0000_0400, {8{32'h1111_0400}});
      tick();
      smp();
      check_grant("t2_first");
      chk("t2_p1_ack_blocked", bus.p1_ack_o, 0);
      tick();
      tick();
      bus.mem_ack_i = 1'b1;
      smp();
      chk("t2_p0_ack", bus.p0_ack_o, 1);
      chk("t2_p1_ack_other", bus.p1_ack_o, 0);
      tick();
      bus.mem_ack_i   = 1'b0;
      bus.p0_enable_i = 1'b0;
      smp();
      chk("t2_bubble", grant_o, 0);
      tick();
      smp();
      check_grant("t2_second");
      tick();
      bus.mem_ack_i = 1'b1;
      smp();
      chk("t2_p1_ack", bus.p1_ack_o, 1);
      chk("t2_p0_ack_other", bus.p0_ack_o, 0);
      tick();
      bus.mem_ack_i   = 1'b0;
      bus.p1_enable_i = 1'b0;

      // Port 0 write-back chained into a fill while port 1 waits
      tick();
      bus.p0_enable_i = 1'b1;
      bus.p0_write_i  = 1'b1;
      bus.p0_addr_i   = 32'h2000_0040;
      bus.p0_data_i   = {8{32'hC0DE_0040}};
      bus.p1_enable_i = 1'b1;
      bus.p1_addr_i   = 32'h3000_0060;
      bus.p1_data_i   = {8{32'h3333_0060}};
      push(2'b01, 1'b1, 32'h2000_0040, {8{32'hC0DE_0040}});
      push(2'b10, 1'b0, 32'h3000_0060, {8{32'h3333_0060}});
      push(2'b01, 1'b0, 32'h2000_0080, {8{32'hF111_0080}});
      tick();
      smp();
      check_grant("t3_wb");
      tick();
      bus.mem_ack_i = 1'b1;
      smp();
      chk("t3_wb_ack", bus.p0_ack_o, 1);
      tick();
      bus.mem_ack_i  = 1'b0;
      bus.p0_write_i = 1'b0;
      bus.p0_addr_i  = 32'h2000_0080;
      bus.p0_data_i  = {8{32'hF111_0080}};
      smp();
      chk("t3_bubble1", grant_o, 0);
      tick();
      smp();
      check_grant("t3_p1");
      tick();
      bus.mem_ack_i = 1'b1;
      smp();
      chk("t3_p1_ack", bus.p1_ack_o, 1);
      tick();
      bus.mem_ack_i   = 1'b0;
      bus.p1_enable_i = 1'b0;
      smp();
      chk("t3_bubble2", grant_o, 0);
      tick();
      smp();
      check_grant("t3_fill");
      tick();
      bus.mem_ack_i = 1'b1;
      smp();
      chk("t3_fill_ack", bus.p0_ack_o, 1);
      tick();
      bus.mem_ack_i   = 1'b0;
      bus.p0_enable_i = 1'b0;

      // Port 1 aborts its request without an ack
      tick();
      bus.p1_enable_i = 1'b1;
      bus.p1_write_i  = 1'b1;
      bus.p1_addr_i   = 32'h4000_00A0;
      bus.p1_data_i   = {8{32'h4444_00A0}};
      push(2'b10, 1'b1, 32'h4000_00A0, {8{32'h4444_00A0}});
      tick();
      smp();
      check_grant("t4");
      tick();
      bus.p1_enable_i = 1'b0;
      smp();
      chk("t4_abort_mem_en", bus.mem_enable_o, 0);
      chk("t4_abort_mem_wr", bus.mem_write_o, 0);
      tick();
      smp();
      chk("t4_idle", grant_o, 0);
      chk("t4_err", err_o, 0);

`ifdef DMEM_ARB_WATCHDOG_EN
      // Memory never acks: forced release and sticky error at grant+8
      tick();
      bus.p0_enable_i = 1'b1;
      bus.p0_write_i  = 1'b0;
      bus.p0_addr_i   = 32'h5000_00C0;
      bus.p0_data_i   = {8{32'h5555_00C0}};
      push(2'b01, 1'b0, 32'h5000_00C0, {8{32'h5555_00C0}});
      tick();
      smp();
      check_grant("t5");
      for (int i = 1; i < 8; i++) begin
         tick();
         smp();
         chk("t5_err_pre", err_o, 0);
         chk("t5_hold", grant_o, 2'b01);
      end
      tick();
      bus.p0_enable_i = 1'b0;
      smp();
      chk("t5_err_set", err_o, 1);
      chk("t5_release", grant_o, 0);
      tick();
      tick();
      smp();
      chk("t5_err_sticky", err_o, 1);
      do_reset();
      smp();
      chk("t5_err_cleared", err_o, 0);
`else
      // Without the watchdog a grant with no ack is held and err_o stays low
      tick();
      bus.p0_enable_i = 1'b1;
      bus.p0_write_i  = 1'b0;
      bus.p0_addr_i   = 32'h5000_00C0;
      bus.p0_data_i   = {8{32'h5555_00C0}};
      push(2'b01, 1'b0, 32'h5000_00C0, {8{32'h5555_00C0}});
      tick();
      smp();
      check_grant("t5");
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      smp();
      chk("t5_hold", grant_o, 2'b01);
      chk("t5_no_err", err_o, 0);
      tick();
      bus.p0_enable_i = 1'b0;
      tick();
      smp();
      chk("t5_idle", grant_o, 0);
`endif

      // Reset during an active port-0 grant
      tick();
      bus.p0_enable_i = 1'b1;
      bus.p0_write_i  = 1'b1;
      bus.p0_addr_i   = 32'h6000_00E0;
      bus.p0_data_i   = {8{32'h6666_00E0}};
      push(2'b01, 1'b1, 32'h6000_00E0, {8{32'h6666_00E0}});
      tick();
      smp();
      check_grant("t6");
      rst_i = 1'b0;
      #1;
      chk("t6_async_grant", grant_o, 0);
      chk("t6_async_mem_en", bus.mem_enable_o, 0);
      bus.p0_enable_i = 1'b0;
      bus.mem_ack_i   = 1'b1;
      #1;
      chk("t6_ack_in_rst", bus.p0_ack_o, 0);
      tick();
      rst_i = 1'b1;
      smp();
      chk("t6_late_ack_p0", bus.p0_ack_o, 0);
      chk("t6_late_ack_p1", bus.p1_ack_o, 0);
      chk("t6_grant_idle", grant_o, 0);
      tick();
      bus.mem_ack_i = 1'b0;
      smp();
      chk("t6_stays_idle", grant_o, 0);

      chk("sb_empty", LINE_W'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
